// File: rtl/lca_dmem_responder_pkg.sv
// Shared types for the LCA data-memory responder: FSM states, burst-length width and beat counter.
package lca_mem_pkg;

  localparam int unsigned LEN_W = 3;

  typedef logic [LEN_W-1:0] beat_cnt_t;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRdata,
    StWdata,
    StWresp
  } dmem_state_e;

endpackage

// File: rtl/lca_dmem_responder_if.sv
// Request / write-data / response channels between the core (master) and the data-memory responder.
interface lca_dmem_responder_if
  import lca_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  beat_cnt_t         req_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_last;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_len, wdata_valid, wdata, rsp_ready,
    input  req_ready, wdata_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_len, wdata_valid, wdata, rsp_ready,
    output req_ready, wdata_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err
  );

endinterface

// File: rtl/lca_dmem_responder_array.sv
// DEPTH x DATA_W word storage: combinational read port, synchronous write port, contents not reset.
module lca_dmem_array #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lca_dmem_responder.sv
// LCA data-memory responder: LW/SW and LM/SM bursts with programmable wait states.
// Optional LCA_DMEM_RANGE_CHECK_EN flags addresses >= DEPTH instead of aliasing them.
module lca_dmem_responder
  import lca_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic                i_clk,
  input logic                i_rst_n,
  lca_dmem_responder_if.slave bus
);

  // DEPTH is expected to be a power of two so the low address bits form the index.
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WCNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned WAIT_LAST = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  dmem_state_e       r_state, w_state_nxt;
  logic              r_started;
  logic              r_we;
  logic              r_err_acc, w_err_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  beat_cnt_t         r_len;
  beat_cnt_t         r_cnt, w_cnt_nxt;
  logic [WCNT_W-1:0] r_wcnt, w_wcnt_nxt;
  logic              w_accept;
  logic              w_oob;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_mem_rdata;

`ifdef LCA_DMEM_RANGE_CHECK_EN
  assign w_oob = (32'(r_addr) >= DEPTH);
`else
  assign w_oob = 1'b0;
`endif

  assign w_idx    = r_addr[IDX_W-1:0];
  // r_started keeps req_ready low until the first clock edge after reset release.
  assign w_accept = (r_state == StIdle) && r_started && bus.req_valid;

  lca_dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (w_mem_we),
    .i_waddr (w_idx),
    .i_wdata (bus.wdata),
    .i_raddr (w_idx),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_started <= 1'b0;
      r_we      <= 1'b0;
      r_err_acc <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_wcnt    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= 1'b1;
      r_err_acc <= w_err_nxt;
      r_addr    <= w_addr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wcnt    <= w_wcnt_nxt;
      if (w_accept) begin
        r_we  <= bus.req_we;
        r_len <= bus.req_len;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_cnt_nxt       = r_cnt;
    w_wcnt_nxt      = r_wcnt;
    w_err_nxt       = r_err_acc;
    w_mem_we        = 1'b0;
    bus.req_ready   = 1'b0;
    bus.wdata_ready = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_rdata   = '0;
    bus.rsp_last    = 1'b0;
    bus.rsp_err     = 1'b0;
    unique case (r_state)
      StIdle: begin
        bus.req_ready = r_started;
        if (w_accept) begin
          w_addr_nxt = bus.req_addr;
          w_cnt_nxt  = '0;
          w_wcnt_nxt = '0;
          w_err_nxt  = 1'b0;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = bus.req_we ? StWdata : StRdata;
          end else begin
            w_state_nxt = StWait;
          end
        end
      end
      StWait: begin
        if (r_wcnt == WCNT_W'(WAIT_LAST)) begin
          w_state_nxt = r_we ? StWdata : StRdata;
        end else begin
          w_wcnt_nxt = r_wcnt + 1'b1;
        end
      end
      StRdata: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = w_oob ? '0 : w_mem_rdata;
        bus.rsp_last  = (r_cnt == r_len);
        bus.rsp_err   = w_oob;
        if (bus.rsp_ready) begin
          w_addr_nxt = r_addr + 1'b1;
          w_cnt_nxt  = r_cnt + 1'b1;
          if (r_cnt == r_len) begin
            w_state_nxt = StIdle;
          end
        end
      end
      StWdata: begin
        bus.wdata_ready = 1'b1;
        if (bus.wdata_valid) begin
          w_mem_we   = !w_oob;
          w_err_nxt  = r_err_acc | w_oob;
          w_addr_nxt = r_addr + 1'b1;
          w_cnt_nxt  = r_cnt + 1'b1;
          if (r_cnt == r_len) begin
            w_state_nxt = StWresp;
          end
        end
      end
      StWresp: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_last  = 1'b1;
        bus.rsp_err   = r_err_acc;
        if (bus.rsp_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_lca_dmem_responder.sv
// Self-checking bench for lca_dmem_responder: one instance with one wait state, one with none.
// Expected beats come from a word-array model of storage; LCA_DMEM_RANGE_CHECK_EN selects range rules.
`timescale 1ns/1ps
module tb_lca_dmem_responder;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 256;
`ifdef LCA_DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] rdata;
    logic          last;
    logic          err;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Stimulus goes to instance a (sel=0, WAIT_CYCLES=1) or b (sel=1, WAIT_CYCLES=0).
  bit            sel         = 1'b0;
  logic          req_valid   = 1'b0;
  logic          req_we      = 1'b0;
  logic [AW-1:0] req_addr    = '0;
  logic [2:0]    req_len     = '0;
  logic          wdata_valid = 1'b0;
  logic [DW-1:0] wdata       = '0;
  logic          rsp_ready   = 1'b0;

  lca_dmem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  lca_dmem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  assign bus_a.req_valid   = req_valid & ~sel;
  assign bus_b.req_valid   = req_valid & sel;
  assign bus_a.req_we      = req_we;
  assign bus_b.req_we      = req_we;
  assign bus_a.req_addr    = req_addr;
  assign bus_b.req_addr    = req_addr;
  assign bus_a.req_len     = req_len;
  assign bus_b.req_len     = req_len;
  assign bus_a.wdata_valid = wdata_valid & ~sel;
  assign bus_b.wdata_valid = wdata_valid & sel;
  assign bus_a.wdata       = wdata;
  assign bus_b.wdata       = wdata;
  assign bus_a.rsp_ready   = rsp_ready & ~sel;
  assign bus_b.rsp_ready   = rsp_ready & sel;

  wire          req_ready   = sel ? bus_b.req_ready   : bus_a.req_ready;
  wire          wdata_ready = sel ? bus_b.wdata_ready : bus_a.wdata_ready;
  wire          rsp_valid   = sel ? bus_b.rsp_valid   : bus_a.rsp_valid;
  wire [DW-1:0] rsp_rdata   = sel ? bus_b.rsp_rdata   : bus_a.rsp_rdata;
  wire          rsp_last    = sel ? bus_b.rsp_last    : bus_a.rsp_last;
  wire          rsp_err     = sel ? bus_b.rsp_err     : bus_a.rsp_err;

  lca_dmem_responder #(
    .ADDR_W (AW), .DATA_W (DW), .DEPTH (DEPTH), .WAIT_CYCLES (1)
  ) dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_a)
  );

  lca_dmem_responder #(
    .ADDR_W (AW), .DATA_W (DW), .DEPTH (DEPTH), .WAIT_CYCLES (0)
  ) dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_b)
  );

  logic [DW-1:0] mdl [2][DEPTH];
  logic [DW-1:0] wbuf [8];
  beat_t         exp_q[$];
  beat_t         obs_q[$];
  beat_t         held;
  bit            hold_v = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic bit oob(input logic [AW-1:0] a);
    return RC && (32'(a) >= 32'(DEPTH));
  endfunction

  function automatic logic [DW-1:0] obs_rd(input int i);
    if (i < obs_q.size()) return obs_q[i].rdata;
    return 'x;
  endfunction

  function automatic logic obs_last(input int i);
    if (i < obs_q.size()) return obs_q[i].last;
    return 1'bx;
  endfunction

  function automatic logic obs_err(input int i);
    if (i < obs_q.size()) return obs_q[i].err;
    return 1'bx;
  endfunction

  // Every response handshake is checked against the model; stalled beats must not change.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", rsp_valid, 1'b1);
        check("hold_rdata", rsp_rdata, held.rdata);
        check("hold_last", rsp_last, held.last);
        check("hold_err", rsp_err, held.err);
      end
      hold_v <= rsp_valid && !rsp_ready;
      held   <= '{rsp_rdata, rsp_last, rsp_err};
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got rdata %0h with no beat required", rsp_rdata);
        end else begin
          check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
          check("rsp_last", rsp_last, exp_q[0].last);
          check("rsp_err", rsp_err, exp_q[0].err);
          void'(exp_q.pop_front());
        end
        obs_q.push_back('{rsp_rdata, rsp_last, rsp_err});
      end
    end
  end

  task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [2:0] len,
                        output int acc);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_len   = len;
    acc       = -1;
    while (acc < 0 && n < 50) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
      end
      n++;
    end
    req_valid = 1'b0;
    check("req_accepted", (acc >= 0), 1'b1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [2:0] len, input bit toggle,
                         output int lat);
    int            acc;
    int            first = -1;
    int            n     = 0;
    logic [AW-1:0] ad;
    for (int b = 0; b <= int'(len); b++) begin
      ad = a + AW'(b);
      exp_q.push_back('{oob(ad) ? '0 : mdl[sel][32'(ad) % DEPTH], (b == int'(len)), oob(ad)});
    end
    obs_q.delete();
    rsp_ready = 1'b1;
    do_req(1'b0, a, len, acc);
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      if (first < 0 && rsp_valid) first = cyc;
      @(posedge clk);
      #1;
      if (toggle) rsp_ready = ~rsp_ready;
      n++;
    end
    check("read_done", exp_q.size(), 0);
    exp_q.delete();
    rsp_ready = 1'b1;
    lat = first - acc + 1;
  endtask

  // Writes wbuf[0..len]; abort_beat >= 0 returns with that beat presented but not taken.
  task automatic do_write(input logic [AW-1:0] a, input logic [2:0] len, input bit gaps,
                          input int abort_beat);
    int            acc;
    int            n;
    bit            any_oob = 1'b0;
    logic [AW-1:0] ad;
    do_req(1'b1, a, len, acc);
    for (int b = 0; b <= int'(len); b++) begin
      ad = a + AW'(b);
      if (gaps && (b % 2 == 1)) begin
        wdata_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      wdata_valid = 1'b1;
      wdata       = wbuf[b];
      if (b == abort_beat) return;
      n = 0;
      @(negedge clk);
      while (!wdata_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("wdata_ready", wdata_ready, 1'b1);
      @(posedge clk);
      #1;
      if (!oob(ad)) mdl[sel][32'(ad) % DEPTH] = wbuf[b];
      any_oob |= oob(ad);
    end
    wdata_valid = 1'b0;
    exp_q.push_back('{'0, 1'b1, any_oob});
    rsp_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wresp_done", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, acc1, acc2, hs, first1, first2, n;
    bit took;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_wdata_ready", wdata_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_last", rsp_last, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", req_ready, 1'b0);
    @(posedge clk);
    #1;
    check("ready_after_edge", req_ready, 1'b1);

    // 1: SW then LW with one wait state
    wbuf[0] = 16'hBEEF;
    do_write(16'h0010, 3'd0, 1'b0, -1);
    do_read(16'h0010, 3'd0, 1'b0, lat);
    check("t1_latency", lat, 2);
    check("t1_nbeats", obs_q.size(), 1);
    check("t1_rdata", obs_rd(0), 16'hBEEF);
    check("t1_last", obs_last(0), 1'b1);

    // 2: eight-beat SM (with write-data bubbles) then LM
    for (int i = 0; i < 8; i++) wbuf[i] = DW'(i + 1);
    do_write(16'h0020, 3'd7, 1'b1, -1);
    do_read(16'h0020, 3'd7, 1'b0, lat);
    check("t2_nbeats", obs_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check("t2_rdata", obs_rd(i), 32'(i + 1));
      check("t2_last", obs_last(i), (i == 7));
    end

    // 3: LM len=3 under a toggling rsp_ready
    do_read(16'h0020, 3'd3, 1'b1, lat);
    check("t3_nbeats", obs_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_rdata", obs_rd(i), 32'(i + 1));

    // 4: address wrap at 0xFFFF, then a store above DEPTH
    wbuf[0] = 16'h1111;
    do_write(16'h00FF, 3'd0, 1'b0, -1);
    wbuf[0] = 16'h2222;
    do_write(16'h0000, 3'd0, 1'b0, -1);
    do_read(16'hFFFF, 3'd1, 1'b0, lat);
    check("t4_nbeats", obs_q.size(), 2);
    check("t4_rdata0", obs_rd(0), RC ? 16'h0000 : 16'h1111);
    check("t4_err0", obs_err(0), RC);
    check("t4_rdata1", obs_rd(1), 16'h2222);
    check("t4_err1", obs_err(1), 1'b0);
    wbuf[0] = 16'h3333;
    do_write(16'h0100, 3'd0, 1'b0, -1);
    do_read(16'h0000, 3'd0, 1'b0, lat);
    check("t4_alias", obs_rd(0), RC ? 16'h2222 : 16'h3333);

    // 5: reset during the third beat of SM len=5
    for (int i = 0; i < 6; i++) wbuf[i] = 16'h5000 + DW'(i);
    do_write(16'h0040, 3'd5, 1'b0, -1);
    for (int i = 0; i < 6; i++) wbuf[i] = 16'hA000 + DW'(i);
    do_write(16'h0040, 3'd5, 1'b0, 2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_req_ready", req_ready, 1'b0);
    check("t5_wdata_ready", wdata_ready, 1'b0);
    check("t5_rsp_valid", rsp_valid, 1'b0);
    check("t5_rsp_last", rsp_last, 1'b0);
    wdata_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_read(16'h0040, 3'd5, 1'b0, lat);
    check("t5_nbeats", obs_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check("t5_rdata", obs_rd(i), (i < 2) ? 32'(16'hA000 + i) : 32'(16'h5000 + i));
    do_read(16'h0041, 3'd0, 1'b0, lat);
    check("t5_lw", obs_rd(0), 16'hA001);

    // 6: no wait states, back-to-back LW/LW with req_valid held throughout
    sel = 1'b1;
    wbuf[0] = 16'h1234;
    wbuf[1] = 16'h5678;
    do_write(16'h0030, 3'd1, 1'b0, -1);
    exp_q.push_back('{mdl[1][8'h30], 1'b1, 1'b0});
    exp_q.push_back('{mdl[1][8'h31], 1'b1, 1'b0});
    obs_q.delete();
    rsp_ready = 1'b1;
    req_we    = 1'b0;
    req_len   = 3'd0;
    req_addr  = 16'h0030;
    req_valid = 1'b1;
    acc1 = -1; acc2 = -1; hs = -1; first1 = -1; first2 = -1; n = 0;
    while (acc2 < 0 && n < 40) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready && hs < 0) hs = cyc + 1;
      if (rsp_valid && first1 < 0) first1 = cyc;
      took = req_ready;
      @(posedge clk);
      #1;
      if (took) begin
        if (acc1 < 0) begin
          acc1     = cyc;
          req_addr = 16'h0031;
        end else begin
          acc2 = cyc;
        end
      end
      n++;
    end
    req_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      if (rsp_valid && first2 < 0) first2 = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    check("t6_done", exp_q.size(), 0);
    check("t6_latency1", first1 - acc1 + 1, 1);
    check("t6_b2b_accept", acc2 - hs, 1);
    check("t6_latency2", first2 - acc2 + 1, 1);
    check("t6_rdata0", obs_rd(0), 16'h1234);
    check("t6_rdata1", obs_rd(1), 16'h5678);
    exp_q.delete();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
